// File: rtl/rv_pkg.sv
// Shared RV fetch-side definitions: datapath width, canonical NOP and fetch FSM states.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Parametric synchronous FIFO with flush; head is read combinationally, push while full is legal with a pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, credit-limited imem requests, in-order response tagging and decode-side buffer.
// Optional misaligned-redirect trap enabled by defining INSTR_FETCH_MISALIGN_TRAP_EN.
//
// state | meaning
// FETCH | issue requests while buffer + in-flight credit remains
// DRAIN | redirect taken; wrong-path responses / stale request still outstanding
// HALT  | misaligned redirect trapped; idle until reset
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_misalign
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state, state_n;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_n, pend_addr, tgt_pc, tag_pc;
    logic [2*XLEN-1:0] buf_head;
    logic [CW-1:0]     inflight, discard, discard_n, fifo_count, tag_count;
    logic              run, req_pend, pend_stale, pend_stale_n, misalign, misalign_n;
    logic              redir, redir_bad, credit, acc, stall, buf_push, buf_pop;
    logic              buf_empty, buf_full, tag_empty, tag_full;
    logic              unused_sig;

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    assign tgt_pc     = redirect_pc;
    assign redir_bad  = redirect_pc[1:0] != 2'b00;
    assign unused_sig = ^{tag_empty, tag_full, buf_full, tag_count};
`else
    assign tgt_pc     = {redirect_pc[XLEN-1:2], 2'b00};
    assign redir_bad  = 1'b0;
    assign unused_sig = ^{tag_empty, tag_full, buf_full, tag_count, redirect_pc[1:0]};
`endif

    // A request stalled by the memory keeps its address even across a redirect.
    assign redir          = redirect_valid && (state != HALT);
    assign credit         = (fifo_count + inflight) < CW'(FIFO_DEPTH);
    assign imem_req_valid = req_pend || (run && (state == FETCH) && credit);
    assign imem_addr      = req_pend ? pend_addr : fetch_pc;
    assign acc            = imem_req_valid && imem_req_ready;
    assign stall          = imem_req_valid && !imem_req_ready;

    assign buf_push = imem_rsp_valid && !redir && (discard == '0) && (state != HALT);
    assign buf_pop  = instr_valid && instr_ready && !redir;

    assign instr_valid    = !buf_empty;
    assign instr          = buf_head[XLEN-1:0];
    assign instr_pc       = buf_head[2*XLEN-1:XLEN];
    assign instr_pc_plus4 = instr_valid ? instr_pc + 32'd4 : '0;
    assign fetch_misalign = misalign;

    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        pend_stale_n = pend_stale && !acc;
        misalign_n   = misalign;
        discard_n    = discard + CW'(acc && pend_stale) - CW'(imem_rsp_valid && (discard != '0));
        if (acc && !pend_stale) fetch_pc_n = fetch_pc + 32'd4;
        case (state)
            DRAIN:   if ((discard == '0) && !req_pend) state_n = FETCH;
            default: state_n = state;
        endcase
        if (redir) begin
            fetch_pc_n   = tgt_pc;
            discard_n    = inflight + CW'(acc) - CW'(imem_rsp_valid);
            pend_stale_n = stall;
            if (redir_bad) begin
                misalign_n = 1'b1;
                state_n    = HALT;
            end else if ((discard_n != '0) || pend_stale_n) begin
                state_n = DRAIN;
            end else begin
                state_n = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            pend_addr  <= RESET_PC;
            inflight   <= '0;
            discard    <= '0;
            run        <= 1'b0;
            req_pend   <= 1'b0;
            pend_stale <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            discard    <= discard_n;
            pend_stale <= pend_stale_n;
            misalign   <= misalign_n;
            run        <= 1'b1;
            req_pend   <= stall;
            inflight   <= inflight + CW'(acc) - CW'(imem_rsp_valid);
            if (stall) pend_addr <= imem_addr;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (acc),
        .push_data (imem_addr),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .head      (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*XLEN)) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data ({tag_pc, imem_rsp_data}),
        .pop       (buf_pop),
        .flush     (redir),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder + architectural PC-stream scoreboard, directed and random tests.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        instr_valid, instr_ready, redirect_valid, fetch_misalign;
    logic [31:0] instr, instr_pc, instr_pc_plus4, redirect_pc;

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    int          vectors = 0, miscompares = 0, cyc = 0;
    int          ready_pct = 100, irdy_pct = 100, lat_min = 1, lat_max = 1;
    bit          redir_now = 1'b0, halted = 1'b0, prev_stall = 1'b0;
    logic [31:0] redir_tgt = '0, exp_pc = RST_PC, prev_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_q.delete(); acc_log.delete(); pop_log.delete();
        redir_now = 1'b0; halted = 1'b0; prev_stall = 1'b0; exp_pc = RST_PC;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One clock: drive at negedge, observe settled handshakes, update memory model and scoreboard.
    task automatic step();
        bit rsp, acc, pop, redir_eff;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        instr_ready    = ($urandom_range(99) < irdy_pct);
        rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
        redirect_valid = redir_now;
        redirect_pc    = redir_now ? redir_tgt : $urandom;
        #1;
        if (prev_stall) begin
            vectors++;
            if (imem_req_valid !== 1'b1 || imem_addr !== prev_addr) begin
                miscompares++;
                $display("FAIL req_hold: valid=%b addr=%h required valid=1 addr=%h", imem_req_valid, imem_addr, prev_addr);
            end
        end
        acc = imem_req_valid && imem_req_ready;
        if (acc) begin
            vectors++;
            if (mem_q.size() >= DEPTH || imem_addr[1:0] !== 2'b00) begin
                miscompares++;
                $display("FAIL req_credit: outstanding=%0d addr=%h required outstanding<%0d aligned", mem_q.size(), imem_addr, DEPTH);
            end
            mem_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
            acc_log.push_back(imem_addr);
        end
        if (rsp) void'(mem_q.pop_front());
        redir_eff = redir_now && !halted;
        pop = instr_valid && instr_ready && !redir_eff;
        if (pop) begin
            vectors++;
            if (halted || instr_pc !== exp_pc || instr !== mem_word(exp_pc) || instr_pc_plus4 !== exp_pc + 32'd4) begin
                miscompares++;
                $display("FAIL stream: pc=%h instr=%h pc4=%h required pc=%h instr=%h pc4=%h halted=%0b",
                         instr_pc, instr, instr_pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4, halted);
            end
            pop_log.push_back(instr_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (redir_eff) begin
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            if (redir_tgt[1:0] != 2'b00) halted = 1'b1;
`endif
            exp_pc = {redir_tgt[31:2], 2'b00};
        end
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_addr;
        redir_now  = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        ready_pct = 70; irdy_pct = 60; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 12; i++) step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({imem_req_valid, instr_valid, fetch_misalign} !== 3'b000 || imem_addr !== RST_PC ||
            instr !== 32'h0 || instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: req=%b addr=%h iv=%b instr=%h pc=%h pc4=%h mis=%b required all 0, addr=%h",
                     imem_req_valid, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4, fetch_misalign, RST_PC);
        end
        do_reset();
    endtask

    task automatic test_stream();
        int first_valid = -1;
        do_reset();
        ready_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 15; i++) begin
            if (first_valid < 0 && instr_valid) first_valid = i;
            step();
        end
        vectors++;
        if (first_valid != 3 || pop_log.size() < 8 || pop_log[0] !== RST_PC) begin
            miscompares++;
            $display("FAIL stream_fill: first_valid=%0d pops=%0d required first_valid=3 pops>=8 starting at %h",
                     first_valid, pop_log.size(), RST_PC);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_pct = 100; irdy_pct = 0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (acc_log.size() != DEPTH || imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure: requests=%0d req_valid=%b required %0d and 0", acc_log.size(), imem_req_valid, DEPTH);
        end
        irdy_pct = 100;
        step();
        vectors++;
        if (imem_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_resume: req_valid=%b required 1", imem_req_valid);
        end
    endtask

    task automatic test_redirect_inflight();
        int n0;
        do_reset();
        ready_pct = 100; irdy_pct = 0; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) step();
        redir_now = 1'b1; redir_tgt = 32'h0000_0100;
        step();
        irdy_pct = 100; lat_min = 1; lat_max = 1;
        n0 = pop_log.size();
        for (int i = 0; i < 20 && pop_log.size() == n0; i++) step();
        vectors++;
        if (pop_log.size() == n0 || pop_log[n0] !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_inflight: pops=%0d first_pc=%h required first_pc=00000100", pop_log.size() - n0,
                     (pop_log.size() > n0) ? pop_log[n0] : 32'hx);
        end
    endtask

    task automatic test_req_stall();
        int n0;
        do_reset();
        ready_pct = 0; irdy_pct = 100; lat_min = 1; lat_max = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
                miscompares++;
                $display("FAIL req_stall: valid=%b addr=%h required 1 and %h", imem_req_valid, imem_addr, RST_PC);
            end
            step();
        end
        redir_now = 1'b1; redir_tgt = 32'h0000_0200;
        step();
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
            miscompares++;
            $display("FAIL stall_redirect_hold: valid=%b addr=%h required 1 and %h", imem_req_valid, imem_addr, RST_PC);
        end
        ready_pct = 100;
        for (int i = 0; i < 20 && acc_log.size() < 2; i++) step();
        vectors++;
        if (acc_log.size() < 2 || acc_log[0] !== RST_PC || acc_log[1] !== 32'h200) begin
            miscompares++;
            $display("FAIL stall_redirect_addr: accepts=%0d required %h then 00000200", acc_log.size(), RST_PC);
        end
        n0 = pop_log.size();
        for (int i = 0; i < 20 && pop_log.size() == n0; i++) step();
        vectors++;
        if (n0 != 0 || pop_log.size() == 0 || pop_log[0] !== 32'h200) begin
            miscompares++;
            $display("FAIL stall_redirect_stream: pops_before=%0d pops=%0d required first pc 00000200", n0, pop_log.size());
        end
    endtask

    task automatic test_redirect_rsp_pop();
        int n0;
        do_reset();
        ready_pct = 100; irdy_pct = 0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rrp_setup: instr_valid=%b required 1", instr_valid);
        end
        redir_now = 1'b1; redir_tgt = 32'h0000_0300; irdy_pct = 100;
        step();
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rrp_flush: instr_valid=%b required 0", instr_valid);
        end
        n0 = pop_log.size();
        for (int i = 0; i < 20 && pop_log.size() == n0; i++) step();
        vectors++;
        if (pop_log.size() == n0 || pop_log[n0] !== 32'h300) begin
            miscompares++;
            $display("FAIL rrp_stream: pops=%0d required first pc 00000300", pop_log.size() - n0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ready_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 2;
        redir_now = 1'b1; redir_tgt = 32'hFFFF_FFF8;
        for (int i = 0; i < 40 && pop_log.size() < 3; i++) step();
        vectors++;
        if (pop_log.size() < 3 || pop_log[0] !== 32'hFFFF_FFF8 || pop_log[2] !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: pops=%0d required FFFFFFF8,FFFFFFFC,00000000", pop_log.size());
        end
    endtask

    task automatic test_misalign();
        int a0, n0;
        do_reset();
        ready_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step();
        redir_now = 1'b1; redir_tgt = 32'h0000_0102;
        step();
        a0 = acc_log.size(); n0 = pop_log.size();
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
        vectors++;
        if (fetch_misalign !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_flag: fetch_misalign=%b required 1", fetch_misalign);
        end
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (acc_log.size() != a0 || pop_log.size() != n0 || imem_req_valid !== 1'b0 || fetch_misalign !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_halt: new_reqs=%0d new_pops=%0d req_valid=%b flag=%b required 0,0,0,1",
                     acc_log.size() - a0, pop_log.size() - n0, imem_req_valid, fetch_misalign);
        end
`else
        vectors++;
        if (fetch_misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_flag: fetch_misalign=%b required 0", fetch_misalign);
        end
        for (int i = 0; i < 20 && pop_log.size() == n0; i++) step();
        vectors++;
        if (pop_log.size() == n0 || pop_log[n0] !== 32'h100 || acc_log.size() == a0) begin
            miscompares++;
            $display("FAIL misalign_mask: pops=%0d required first pc 00000100", pop_log.size() - n0);
        end
`endif
    endtask

    task automatic test_random();
        int n0;
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            ready_pct = int'($urandom_range(100, 30));
            irdy_pct  = int'($urandom_range(100, 20));
            lat_min = 1; lat_max = int'($urandom_range(4, 1));
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(99) < 4) begin
                    redir_now = 1'b1;
                    redir_tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                        : ($urandom & 32'h0000_3FFC);
                end
                step();
            end
        end
        ready_pct = 100; irdy_pct = 100; lat_max = 1;
        n0 = pop_log.size();
        for (int i = 0; i < 40 && pop_log.size() < n0 + 5; i++) step();
        vectors++;
        if (pop_log.size() < n0 + 5) begin
            miscompares++;
            $display("FAIL random_liveness: pops=%0d required >=5 within 40 cycles", pop_log.size() - n0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: sim time %0t required completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_req_stall();
        test_redirect_rsp_pop();
        test_wrap();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
